// File: rtl/uart_rcvr.sv
// uart_rcvr: oversampling UART receiver.
//
// Recovers frames of one start bit (0), `wordsize` data bits LSB first and one
// stop bit (1) from an idle-high serial line. The line is examined only on
// `enabler` strobes (oversample x bit rate). The start bit is revalidated on
// every strobe up to its centre, and each data bit is sampled at its centre.
// The completed byte is handed to the host with a ready flag, an overrun flag
// and, optionally, a framing-error flag.
//
// Optional feature macro: UART_RCV_STOP_CHECK_EN
//   defined   : error2 <= ~serial_in at the stop-bit sample (framing error).
//   undefined : stop bit not checked, error2 tied to 0.
//
// Ports:
//   clk                 in   system clock, rising edge
//   reset               in   asynchronous, active-low reset
//   enabler             in   single-clk sample strobe at oversample x bit rate
//   serial_in           in   serial line, idle high, synchronous to clk
//   read_done           in   host pulse: current byte consumed
//   rcv_datareg         out  last received byte
//   read_not_ready_out  out  byte valid and unread
//   error1              out  overrun: frame completed while previous byte unread
//   error2              out  framing error: stop bit sampled 0

module uart_rcvr #(
  parameter int unsigned wordsize   = 8,  // data bits per frame, 4..8
  parameter int unsigned oversample = 8   // strobes per bit time, power of two >= 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enabler,
  input  logic                serial_in,
  input  logic                read_done,
  output logic [wordsize-1:0] rcv_datareg,
  output logic                read_not_ready_out,
  output logic                error1,
  output logic                error2
);

  localparam int unsigned ScW = $clog2(oversample);

  // Strobe index of the start-bit centre, and of every later bit centre.
  localparam logic [ScW-1:0] HalfM1   = ScW'(oversample / 2 - 1);
  localparam logic [ScW-1:0] LastSmp  = ScW'(oversample - 1);
  localparam logic [3:0]     WordBits = 4'(wordsize);

  typedef enum logic [1:0] {
    StIdle,
    StStarting,
    StReceiving
  } state_e;

  state_e              state_q, state_d;
  logic [ScW-1:0]      sample_count_q, sample_count_d;
  logic [3:0]          bit_count_q, bit_count_d;
  logic [wordsize-1:0] rcv_shftreg_q, rcv_shftreg_d;
  logic [wordsize-1:0] rcv_datareg_q, rcv_datareg_d;
  logic                read_not_ready_q, read_not_ready_d;
  logic                error1_q, error1_d;
  logic                frame_end;

`ifdef UART_RCV_STOP_CHECK_EN
  logic                error2_q, error2_d;
`endif

  always_comb begin
    state_d          = state_q;
    sample_count_d   = sample_count_q;
    bit_count_d      = bit_count_q;
    rcv_shftreg_d    = rcv_shftreg_q;
    rcv_datareg_d    = rcv_datareg_q;
    read_not_ready_d = read_not_ready_q;
    error1_d         = error1_q;
    frame_end        = 1'b0;
`ifdef UART_RCV_STOP_CHECK_EN
    error2_d         = error2_q;
`endif

    if (enabler) begin
      unique case (state_q)
        StIdle: begin
          if (!serial_in) begin
            state_d        = StStarting;
            sample_count_d = '0;
          end
        end
        StStarting: begin
          // Any high sample before the start-bit centre is a glitch.
          if (serial_in) begin
            state_d        = StIdle;
            sample_count_d = '0;
          end else if (sample_count_q == HalfM1) begin
            state_d        = StReceiving;
            sample_count_d = '0;
            bit_count_d    = '0;
          end else begin
            sample_count_d = sample_count_q + 1'b1;
          end
        end
        StReceiving: begin
          if (sample_count_q == LastSmp) begin
            sample_count_d = '0;
            if (bit_count_q == WordBits) begin
              // Stop-bit sample: frame complete, idle resumes on this strobe.
              frame_end = 1'b1;
              state_d   = StIdle;
            end else begin
              rcv_shftreg_d = {serial_in, rcv_shftreg_q[wordsize-1:1]};
              bit_count_d   = bit_count_q + 1'b1;
            end
          end else begin
            sample_count_d = sample_count_q + 1'b1;
          end
        end
        default: state_d = StIdle;
      endcase
    end

    // Host read clears flags on any clk edge; a coincident frame end overrides.
    if (read_done) begin
      read_not_ready_d = 1'b0;
      error1_d         = 1'b0;
`ifdef UART_RCV_STOP_CHECK_EN
      error2_d         = 1'b0;
`endif
    end

    if (frame_end) begin
      if (!read_not_ready_q || read_done) begin
        rcv_datareg_d    = rcv_shftreg_q;
        read_not_ready_d = 1'b1;
      end else begin
        // Previous byte still unread: keep it, drop the new one.
        error1_d = 1'b1;
      end
`ifdef UART_RCV_STOP_CHECK_EN
      error2_d = ~serial_in;
`endif
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q          <= StIdle;
      sample_count_q   <= '0;
      bit_count_q      <= '0;
      rcv_shftreg_q    <= '0;
      rcv_datareg_q    <= '0;
      read_not_ready_q <= 1'b0;
      error1_q         <= 1'b0;
`ifdef UART_RCV_STOP_CHECK_EN
      error2_q         <= 1'b0;
`endif
    end else begin
      state_q          <= state_d;
      sample_count_q   <= sample_count_d;
      bit_count_q      <= bit_count_d;
      rcv_shftreg_q    <= rcv_shftreg_d;
      rcv_datareg_q    <= rcv_datareg_d;
      read_not_ready_q <= read_not_ready_d;
      error1_q         <= error1_d;
`ifdef UART_RCV_STOP_CHECK_EN
      error2_q         <= error2_d;
`endif
    end
  end

  assign rcv_datareg        = rcv_datareg_q;
  assign read_not_ready_out = read_not_ready_q;
  assign error1             = error1_q;
`ifdef UART_RCV_STOP_CHECK_EN
  assign error2             = error2_q;
`else
  assign error2             = 1'b0;
`endif

endmodule
